// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared defaults and width helpers for front-panel button blocks
package button_pkg;

  localparam int TICK_PERIOD_DEF = 4_000_000;
  localparam int STABLE_CNT_DEF  = 3;
  localparam int PRESCALE_W      = 32;
  localparam int DEB_CNT_W       = 4;
  localparam int EVT_PRESS_W     = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Event id width; a single-bit id is kept even for one or two buttons.
  function automatic int evt_id_width(input int n_btn);
    return (clog2(n_btn) < 1) ? 1 : clog2(n_btn);
  endfunction

endpackage

// File: rtl/btn_rr_arbiter.sv
// rtl/btn_rr_arbiter.sv - round-robin pick of first request after the last granted id
module btn_rr_arbiter
  import button_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [ID_W-1:0] grant,
  output logic            any
);

  int idx;

  // Scan N slots starting one past the last grant; the last grant itself is visited last.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!any && req[idx]) begin
        grant = idx[ID_W-1:0];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// rtl/button_event_scheduler.sv - shared-tick debounce for N buttons with round-robin event port
module button_event_scheduler
  import button_pkg::*;
#(
  parameter  int N_BTN       = 4,
  parameter  int TICK_PERIOD = TICK_PERIOD_DEF,
  parameter  int STABLE_CNT  = STABLE_CNT_DEF,
  localparam int ID_W        = evt_id_width(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_press,
  output logic             evt_lost,
  input  logic             lost_clr
);

  logic [N_BTN-1:0]      sync1, sync2;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  tick;
  logic [DEB_CNT_W-1:0]  cnt [N_BTN];
  logic [N_BTN-1:0]      pend, dir;
  logic [N_BTN-1:0]      ev, taken;
  logic [ID_W-1:0]       last_id, grant;
  logic                  any_pend, load, overwrite;

  assign tick = (pre_cnt == PRESCALE_W'(TICK_PERIOD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= '0;
      sync2   <= '0;
      pre_cnt <= '0;
    end else begin
      sync1   <= btn_in;
      sync2   <= sync1;
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

  btn_rr_arbiter #(.N(N_BTN), .ID_W(ID_W)) u_arb (
    .req   (pend),
    .last  (last_id),
    .grant (grant),
    .any   (any_pend)
  );

  assign load = (!evt_valid || evt_ready) && any_pend;

  // ev marks the tick on which a button's change has been seen STABLE_CNT times in a row.
  always_comb begin
    ev    = '0;
    taken = '0;
    if (load) taken[grant] = 1'b1;
    for (int i = 0; i < N_BTN; i++) begin
      ev[i] = tick && (sync2[i] != btn_state[i]) &&
              (cnt[i] == DEB_CNT_W'(STABLE_CNT - 1));
    end
    overwrite = |(ev & pend & ~taken);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_state <= '0;
      pend      <= '0;
      dir       <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (tick) begin
          if (sync2[i] == btn_state[i]) begin
            cnt[i] <= '0;
          end else if (ev[i]) begin
            cnt[i]       <= '0;
            btn_state[i] <= ~btn_state[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
        // A fresh event outranks the clear from a same-cycle grant.
        if (ev[i]) begin
          pend[i] <= 1'b1;
          dir[i]  <= ~btn_state[i];
        end else if (taken[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_press <= 1'b0;
      evt_lost  <= 1'b0;
      last_id   <= '0;
    end else begin
      if (load) begin
        evt_valid <= 1'b1;
        evt_id    <= grant;
        evt_press <= dir[grant];
        last_id   <= grant;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (overwrite) evt_lost <= 1'b1;
      else if (lost_clr) evt_lost <= 1'b0;
    end
  end

endmodule
